// File: rtl/dps_lsflags_read_arbiter.sv
// Round-robin arbiter sharing the clear-on-read LS-flags read port.
// One read strobe per grant; the returned word is routed to the winner.
module dps_lsflags_read_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 8
)(
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic [N_REQ-1:0] iREQ_VALID,
  output logic [N_REQ-1:0] oREQ_BUSY,
  output logic [N_REQ-1:0] oRESP_VALID,
  output logic [ID_W-1:0]  oRESP_ID,
  output logic [31:0]      oRESP_DATA,
  output logic             oRESP_ERR,
  output logic             oLSF_READ_VALID,
  input  logic             iLSF_VALID,
  input  logic [31:0]      iLSF_DATA
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state, stateNxt;
  logic [N_REQ-1:0] pending, pendingNxt;
  logic [ID_W-1:0]  ptr, ptrNxt;
  logic [ID_W-1:0]  grantId, grantNxt;
  logic [7:0]       cnt, cntNxt;
  logic [N_REQ-1:0] respValidNxt;
  logic [ID_W-1:0]  respIdNxt;
  logic [31:0]      respDataNxt;
  logic             respErrNxt;
  logic             readNxt;

  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] reqEff;
  logic             found;
  logic [ID_W-1:0]  pick;
  int               idx;
  int               nx;

  // Busy covers queued requests plus the one currently being served.
  always_comb begin
    oREQ_BUSY = pending;
    if (state != ST_IDLE) oREQ_BUSY[grantId] = 1'b1;
  end

  assign accept = iREQ_VALID & ~oREQ_BUSY;
  assign reqEff = pending | accept;

  // Rotating priority search starting at the pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && reqEff[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    nx = int'(pick) + 1;
    if (nx >= N_REQ) nx = 0;
  end

  // Next-state, bookkeeping and registered-output decode.
  always_comb begin
    stateNxt     = state;
    pendingNxt   = pending | accept;
    ptrNxt       = ptr;
    grantNxt     = grantId;
    cntNxt       = cnt;
    respValidNxt = '0;
    respIdNxt    = oRESP_ID;
    respDataNxt  = oRESP_DATA;
    respErrNxt   = oRESP_ERR;
    readNxt      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          pendingNxt[pick] = 1'b0;
          grantNxt         = pick;
          ptrNxt           = ID_W'(nx);
          stateNxt         = ST_ISSUE;
          readNxt          = 1'b1;
        end
      end
      ST_ISSUE: begin
        cntNxt   = '0;
        stateNxt = ST_WAIT;
      end
      ST_WAIT: begin
        unique case (1'b1)
          iLSF_VALID: begin
            respDataNxt = iLSF_DATA;
            respErrNxt  = 1'b0;
            stateNxt    = ST_RESP;
          end
          (cnt == 8'(TIMEOUT - 1)): begin
            respDataNxt = '0;
            respErrNxt  = 1'b1;
            stateNxt    = ST_RESP;
          end
          default: cntNxt = cnt + 8'd1;
        endcase
        if (stateNxt == ST_RESP) begin
          respValidNxt[grantId] = 1'b1;
          respIdNxt             = grantId;
        end
      end
      ST_RESP: stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  // State and output registers; soft reset mirrors the async reset.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state           <= ST_IDLE;
      pending         <= '0;
      ptr             <= '0;
      grantId         <= '0;
      cnt             <= '0;
      oRESP_VALID     <= '0;
      oRESP_ID        <= '0;
      oRESP_DATA      <= '0;
      oRESP_ERR       <= 1'b0;
      oLSF_READ_VALID <= 1'b0;
    end else if (iRESET_SYNC) begin
      state           <= ST_IDLE;
      pending         <= '0;
      ptr             <= '0;
      grantId         <= '0;
      cnt             <= '0;
      oRESP_VALID     <= '0;
      oRESP_ID        <= '0;
      oRESP_DATA      <= '0;
      oRESP_ERR       <= 1'b0;
      oLSF_READ_VALID <= 1'b0;
    end else begin
      state           <= stateNxt;
      pending         <= pendingNxt;
      ptr             <= ptrNxt;
      grantId         <= grantNxt;
      cnt             <= cntNxt;
      oRESP_VALID     <= respValidNxt;
      oRESP_ID        <= respIdNxt;
      oRESP_DATA      <= respDataNxt;
      oRESP_ERR       <= respErrNxt;
      oLSF_READ_VALID <= readNxt;
    end
  end

endmodule

// File: tb/tb_dps_lsflags_read_arbiter.sv
// Bench for the LS-flags read arbiter.
// Scoreboard of expected responses plus a 1-cycle flags model.
module tb_dps_lsflags_read_arbiter;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;

  logic             iCLOCK = 1'b0;
  logic             inRESET;
  logic             iRESET_SYNC;
  logic [N_REQ-1:0] iREQ_VALID;
  logic [N_REQ-1:0] oREQ_BUSY;
  logic [N_REQ-1:0] oRESP_VALID;
  logic [ID_W-1:0]  oRESP_ID;
  logic [31:0]      oRESP_DATA;
  logic             oRESP_ERR;
  logic             oLSF_READ_VALID;
  logic             iLSF_VALID;
  logic [31:0]      iLSF_DATA;

  dps_lsflags_read_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .iCLOCK(iCLOCK),
    .inRESET(inRESET),
    .iRESET_SYNC(iRESET_SYNC),
    .iREQ_VALID(iREQ_VALID),
    .oREQ_BUSY(oREQ_BUSY),
    .oRESP_VALID(oRESP_VALID),
    .oRESP_ID(oRESP_ID),
    .oRESP_DATA(oRESP_DATA),
    .oRESP_ERR(oRESP_ERR),
    .oLSF_READ_VALID(oLSF_READ_VALID),
    .iLSF_VALID(iLSF_VALID),
    .iLSF_DATA(iLSF_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] flags;
    int          expId;
  } tvec_t;

  exp_t  sbq[$];
  exp_t  me;
  tvec_t tv[4];

  int cyc     = 0;
  int checks  = 0;
  int passed  = 0;
  int strobes = 0;
  int c0;
  int s0;

  // Flags block model: registered return one cycle after the strobe.
  logic        retEn = 1'b1;
  logic        stray = 1'b0;
  logic        lsfV  = 1'b0;
  logic [31:0] lsfD  = '0;
  logic [31:0] flagsVal = '0;

  always @(posedge iCLOCK) begin
    cyc  <= cyc + 1;
    lsfV <= oLSF_READ_VALID & retEn;
    lsfD <= flagsVal;
  end

  assign iLSF_VALID = lsfV | stray;
  assign iLSF_DATA  = lsfD;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Response monitor pops the scoreboard on every response strobe.
  always @(negedge iCLOCK) begin
    if (oLSF_READ_VALID === 1'b1) strobes++;
    if (inRESET === 1'b1 && oRESP_VALID !== '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'(oRESP_VALID), 32'h0);
      end else begin
        me = sbq.pop_front();
        chk("resp_id", 32'(oRESP_ID), 32'(me.id));
        chk("resp_onehot", 32'(oRESP_VALID), 32'h1 << me.id);
        chk("resp_data", oRESP_DATA, me.data);
        chk("resp_err", 32'(oRESP_ERR), 32'(me.err));
        if (me.cyc >= 0) chk("resp_cycle", 32'(cyc), 32'(me.cyc));
      end
    end
  end

  task automatic step();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic samp();
    @(negedge iCLOCK);
  endtask

  task automatic pushExp(input int id, input logic [31:0] d,
                         input logic e, input int c);
    exp_t x;
    x.id = id;
    x.data = d;
    x.err = e;
    x.cyc = c;
    sbq.push_back(x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      step();
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'h0);
      sbq.delete();
    end
    repeat (2) step();
  endtask

  task automatic softReset();
    iRESET_SYNC = 1'b1;
    step();
    iRESET_SYNC = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    inRESET     = 1'b0;
    iRESET_SYNC = 1'b0;
    iREQ_VALID  = '0;

    tv[0] = '{4'b0100, 32'h0000_0002, 2};
    tv[1] = '{4'b0001, 32'hDEAD_BEEF, 0};
    tv[2] = '{4'b1000, 32'h8000_0001, 3};
    tv[3] = '{4'b0010, 32'h0000_0000, 1};

    // Reset state
    repeat (2) samp();
    chk("rst_busy", 32'(oREQ_BUSY), 32'h0);
    chk("rst_rvalid", 32'(oRESP_VALID), 32'h0);
    chk("rst_rid", 32'(oRESP_ID), 32'h0);
    chk("rst_rdata", oRESP_DATA, 32'h0);
    chk("rst_rerr", 32'(oRESP_ERR), 32'h0);
    chk("rst_strobe", 32'(oLSF_READ_VALID), 32'h0);
    inRESET = 1'b1;
    step();
    step();

    // Table-driven single requests with cycle-exact strobe/busy checks
    for (int v = 0; v < 4; v++) begin
      flagsVal = tv[v].flags;
      c0 = cyc;
      s0 = strobes;
      pushExp(tv[v].expId, tv[v].flags, 1'b0, c0 + 3);
      iREQ_VALID = tv[v].mask;
      for (int k = 0; k < 5; k++) begin
        samp();
        chk("tv_strobe", 32'(oLSF_READ_VALID), 32'(k == 1));
        chk("tv_busy", 32'(oREQ_BUSY),
            (k >= 1 && k <= 3) ? 32'(tv[v].mask) : 32'h0);
        step();
        iREQ_VALID = '0;
      end
      chk("tv_nstrobe", 32'(strobes - s0), 32'h1);
      chk("tv_sb_empty", 32'(sbq.size()), 32'h0);
    end

    // Round robin from pointer 0
    softReset();
    flagsVal = 32'h0000_0055;
    c0 = cyc;
    for (int i = 0; i < 4; i++) pushExp(i, 32'h55, 1'b0, c0 + 3 + 4 * i);
    iREQ_VALID = 4'b1111;
    samp();
    step();
    iREQ_VALID = '0;
    samp();
    chk("rr_busy_all", 32'(oREQ_BUSY), 32'hF);
    drain();
    c0 = cyc;
    pushExp(0, 32'h55, 1'b0, c0 + 3);
    pushExp(1, 32'h55, 1'b0, c0 + 7);
    iREQ_VALID = 4'b0011;
    step();
    iREQ_VALID = '0;
    drain();

    // Hog on requester 0, single pulse from requester 3
    softReset();
    flagsVal = 32'h0000_0077;
    c0 = cyc;
    pushExp(0, 32'h77, 1'b0, c0 + 3);
    pushExp(3, 32'h77, 1'b0, c0 + 7);
    pushExp(0, 32'h77, 1'b0, c0 + 11);
    for (int k = 0; k < 9; k++) begin
      iREQ_VALID = 4'b0001 | ((k == 1) ? 4'b1000 : 4'b0000);
      step();
    end
    iREQ_VALID = '0;
    drain();

    // Merge: second pulse while busy is ignored
    flagsVal = 32'h0000_1234;
    c0 = cyc;
    s0 = strobes;
    pushExp(1, 32'h1234, 1'b0, c0 + 3);
    for (int k = 0; k < 6; k++) begin
      iREQ_VALID = (k == 0 || k == 2) ? 4'b0010 : 4'b0000;
      samp();
      if (k == 4) chk("merge_busy_c4", 32'(oREQ_BUSY), 32'h0);
      step();
    end
    iREQ_VALID = '0;
    drain();
    chk("merge_nstrobe", 32'(strobes - s0), 32'h1);

    // Timeout with no return, then a stray valid in cycle 12
    retEn = 1'b0;
    flagsVal = 32'hFFFF_FFFF;
    c0 = cyc;
    s0 = strobes;
    pushExp(1, 32'h0, 1'b1, c0 + 10);
    for (int k = 0; k < 16; k++) begin
      iREQ_VALID = (k == 0) ? 4'b0010 : 4'b0000;
      stray = (k == 12);
      samp();
      if (k == 13) begin
        chk("to_hold_err", 32'(oRESP_ERR), 32'h1);
        chk("to_hold_data", oRESP_DATA, 32'h0);
        chk("to_hold_id", 32'(oRESP_ID), 32'h1);
        chk("to_busy", 32'(oREQ_BUSY), 32'h0);
      end
      step();
    end
    stray = 1'b0;
    retEn = 1'b1;
    chk("to_nstrobe", 32'(strobes - s0), 32'h1);
    chk("to_sb_empty", 32'(sbq.size()), 32'h0);

    // Soft reset while in WAIT with another request pending
    flagsVal = 32'h0000_0099;
    s0 = strobes;
    iREQ_VALID = 4'b0101;
    step();
    iREQ_VALID = '0;
    step();
    iRESET_SYNC = 1'b1;
    samp();
    step();
    iRESET_SYNC = 1'b0;
    samp();
    chk("sr_busy", 32'(oREQ_BUSY), 32'h0);
    chk("sr_rvalid", 32'(oRESP_VALID), 32'h0);
    chk("sr_rid", 32'(oRESP_ID), 32'h0);
    chk("sr_rerr", 32'(oRESP_ERR), 32'h0);
    repeat (6) step();
    c0 = cyc;
    pushExp(0, 32'h99, 1'b0, c0 + 3);
    pushExp(3, 32'h99, 1'b0, c0 + 7);
    iREQ_VALID = 4'b1001;
    step();
    iREQ_VALID = '0;
    drain();
    chk("sr_nstrobe", 32'(strobes - s0), 32'h3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dps_lsflags_read_arbiter.md
Name: dps_lsflags_read_arbiter

Overview:
- Shares the single clear-on-read LS-flags register port between N_REQ requesters, such as per-core interrupt handlers and the debug unit.
- Accepts single-cycle read pulses and arbitrates round-robin.
- Issues exactly one read strobe to the flags block, waits for its registered return, and routes the 32-bit flags word back to the granted requester.
- Sits between the requesters and the LS-flags register; it is the only driver of that register's read strobe.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).
- TIMEOUT, 8, maximum cycles spent in WAIT before an error response is forced (1..255).

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  reset: asynchronous, active-low
- iRESET_SYNC  in  1  synchronous soft reset
- iREQ_VALID  in  N_REQ  per-requester single-cycle read request pulse
- oREQ_BUSY  out  N_REQ  requester i has a pending or in-flight read
- oRESP_VALID  out  N_REQ  one-hot, 1-cycle response strobe
- oRESP_ID  out  ID_W  index of the responding requester
- oRESP_DATA  out  32  flags word returned
- oRESP_ERR  out  1  response produced by timeout; data is 0
- oLSF_READ_VALID  out  1  read strobe to the flags register
- iLSF_VALID  in  1  flags register return valid
- iLSF_DATA  in  32  flags register return data

Behaviour:
- Reset: inRESET is asynchronous, active-low; clock is iCLOCK. Under reset:
  - all outputs 0;
  - state IDLE;
  - pending[] = 0;
  - round-robin pointer = 0;
  - timeout counter = 0.
- iRESET_SYNC acts identically at the clock edge, from any state. Any in-flight read is discarded and no response is issued.
- Pending bits:
  - pending[i] is set at the edge where iREQ_VALID[i]=1 and oREQ_BUSY[i]=0.
  - A pulse while busy is ignored: it is merged and produces no extra response.
  - oREQ_BUSY[i] = pending[i] | (state != IDLE && grant_id == i).
- Arbitration happens only in IDLE. The grant goes to the lowest index >= pointer with pending set, wrapping around to index 0.
  - On grant: grant_id is latched, pending[grant_id] is cleared, pointer = (grant_id + 1) mod N_REQ.
- State machine (all transitions on the clock edge):
  - IDLE -> ISSUE when any pending bit is set.
  - ISSUE: oLSF_READ_VALID=1 for exactly this one cycle. Timeout counter cleared. Next state WAIT.
  - WAIT, iLSF_VALID=1: register oRESP_DATA = iLSF_DATA, oRESP_ERR = 0. Next state RESP.
  - WAIT, counter reaches TIMEOUT-1 without iLSF_VALID: register oRESP_DATA = 0, oRESP_ERR = 1. Next state RESP.
  - WAIT, otherwise: counter increments.
  - RESP: oRESP_VALID[grant_id]=1 and oRESP_ID = grant_id for one cycle. Next state IDLE.
- Outputs:
  - oRESP_VALID is 0 outside RESP.
  - oRESP_DATA, oRESP_ID and oRESP_ERR hold their last values outside RESP.
  - oLSF_READ_VALID is a registered decode of state == ISSUE and is never asserted twice per grant.
- Latency, with a flags block of 1-cycle registered return:
  - pulse in cycle 0 -> ISSUE in cycle 1 -> WAIT in cycle 2 (iLSF_VALID seen) -> RESP in cycle 3;
  - oREQ_BUSY[i] falls in cycle 4;
  - back-to-back grants are 4 cycles apart.
- iLSF_VALID outside WAIT is a stray and is ignored; no state or output changes.
- A pulse from a requester in the same cycle as another requester's grant is accepted normally. It is served in a later round-robin turn.
- The arbiter never issues a read without a pending grant. Consequently, flags are consumed only by a real requester.

Test Plan:
- Single request: flags model holds 0x0000_0002. Pulse iREQ_VALID=4'b0100 at cycle 0 -> oLSF_READ_VALID=1 in cycle 1 only; in cycle 3 oRESP_VALID=4'b0100, oRESP_ID=2, oRESP_DATA=0x2, oRESP_ERR=0; oREQ_BUSY[2]=1 in cycles 1-3 and 0 in cycle 4.
- Round-robin: pulse 4'b1111 simultaneously with pointer=0 -> responses in order ID 0,1,2,3, at cycles 3,7,11,15. Then pulse 4'b0011 -> order ID 0,1 (pointer had wrapped to 0).
- Fairness under a hog: requester 0 re-pulses immediately after each response while requester 3 pulses once -> requester 3 is served no later than the second grant after its pulse.
- Merge while busy: requester 1 pulses at cycles 0 and 2 -> exactly one read strobe and one response, at cycle 3; the cycle-2 pulse is ignored.
- Timeout: flags model never returns iLSF_VALID, TIMEOUT=8, single pulse at cycle 0 -> RESP in cycle 10 with oRESP_DATA=0, oRESP_ERR=1, ID correct. A stray iLSF_VALID in cycle 12 produces no response.
- Soft reset mid-flight: iRESET_SYNC=1 in cycle 2 (WAIT) with requesters 0 and 2 pending -> no response is issued, all oREQ_BUSY=0 in cycle 3, and the next pulse is arbitrated starting from pointer 0.
